// File: rtl/seq_restoring_divider_if.sv
// Start/busy/done handshake bundle for the sequential divider.
// The master drives operands; the slave returns results.
interface seq_restoring_divider_if #(
    parameter int N = 6
);
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_restoring_divider.sv
// N-bit unsigned restoring divider, one ripple-subtractor trial per clock.
// Used mainly to split minute/second values into tens and units.
module seq_restoring_divider #(
    parameter int N = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    seq_restoring_divider_if.slave bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  d_q, d_d;
    logic [N:0]    r_q, r_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  quo_q, quo_d;
    logic [N-1:0]  rem_q, rem_d;
    logic          dbz_q, dbz_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [N:0]    s;
    logic [N:0]    m;
    logic [N:0]    t;
    logic [N+1:0]  bw;

    // Gate-level ripple subtractor: t = s - m, borrow out in bw[N+1].
    always_comb begin
        s     = (N+1)'({r_q, q_q[N-1]});
        m     = {1'b0, d_q};
        bw    = '0;
        t     = '0;
        for (int i = 0; i <= N; i++) begin
            t[i]    = s[i] ^ m[i] ^ bw[i];
            bw[i+1] = (~s[i] & m[i]) | (~(s[i] ^ m[i]) & bw[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        d_d     = d_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            RUN: begin
                r_d   = bw[N+1] ? s : t;
                q_d   = (q_q << 1) | {{(N-1){1'b0}}, ~bw[N+1]};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    quo_d   = q_d;
                    rem_d   = r_d[N-1:0];
                end
            end
            default: begin
                if (state_q == DONE)
                    state_d = IDLE;
                if (bus.start) begin
                    q_d   = bus.dividend;
                    d_d   = bus.divisor;
                    r_d   = '0;
                    cnt_d = CW'(N);
                    dbz_d = 1'b0;
                    if (bus.divisor == '0) begin
                        state_d = DONE;
                        quo_d   = '1;
                        rem_d   = bus.dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            d_q     <= d_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and sweep checks for seq_restoring_divider at N=6.
// Outputs are sampled 1 time unit after each rising edge.
module tb_seq_restoring_divider;
    localparam int N = 6;

    logic clk = 1'b0;
    logic rst;
    int   nvec = 0;
    int   nerr = 0;

    seq_restoring_divider_if #(.N(N)) bus ();

    seq_restoring_divider #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        nvec++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input int a, input int b);
        bus.dividend = a[N-1:0];
        bus.divisor  = b[N-1:0];
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
    endtask

    // k is the cycle index after the accepting edge (1 = first cycle)
    task automatic wait_done(input int k0, output int k, output int nb);
        k  = k0;
        nb = 0;
        while (!bus.done && k < 20) begin
            nb += int'(bus.busy);
            tick();
            k++;
        end
        if (!bus.done)
            chk("done_timeout", 0, 1);
    endtask

    task automatic run_case(input string tag, input int a, input int b,
                            input int eq, input int er, input int edbz,
                            input int ek, input int enb);
        int k, nb;
        apply(a, b);
        wait_done(1, k, nb);
        chk({tag, "_lat"}, k, ek);
        chk({tag, "_busy"}, nb, enb);
        chk({tag, "_q"}, int'(bus.quotient), eq);
        chk({tag, "_r"}, int'(bus.remainder), er);
        chk({tag, "_dbz"}, int'(bus.div_by_zero), edbz);
        tick();
        chk({tag, "_done_clr"}, int'(bus.done), 0);
        chk({tag, "_q_hold"}, int'(bus.quotient), eq);
    endtask

    initial begin
        int k, nb, dn;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) tick();
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_q", int'(bus.quotient), 0);
        chk("rst_r", int'(bus.remainder), 0);
        chk("rst_dbz", int'(bus.div_by_zero), 0);

        bus.dividend = 6'd59;
        bus.divisor  = 6'd10;
        bus.start    = 1'b1;
        tick();
        chk("rst_over_start", int'(bus.busy), 0);
        bus.start = 1'b0;
        rst       = 1'b0;
        tick();

        run_case("d59_10", 59, 10, 5, 9, 0, 7, 6);
        run_case("d63_1", 63, 1, 63, 0, 0, 7, 6);
        run_case("d5_7", 5, 7, 0, 5, 0, 7, 6);
        run_case("d63_63", 63, 63, 1, 0, 0, 7, 6);
        run_case("d0_9", 0, 9, 0, 0, 0, 7, 6);
        run_case("d42_0", 42, 0, 63, 42, 1, 1, 0);

        apply(45, 10);
        tick();
        tick();
        bus.dividend = 6'd12;
        bus.divisor  = 6'd3;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(4, k, nb);
        chk("ign_lat", k, 7);
        chk("ign_q", int'(bus.quotient), 4);
        chk("ign_r", int'(bus.remainder), 5);
        apply(12, 3);
        wait_done(1, k, nb);
        chk("b2b_lat", k, 7);
        chk("b2b_q", int'(bus.quotient), 4);
        chk("b2b_r", int'(bus.remainder), 0);
        tick();

        apply(59, 10);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_done", int'(bus.done), 0);
        chk("abort_q", int'(bus.quotient), 0);
        chk("abort_r", int'(bus.remainder), 0);
        chk("abort_dbz", int'(bus.div_by_zero), 0);
        dn = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            dn += int'(bus.done) + int'(bus.busy);
        end
        chk("abort_quiet", dn, 0);
        run_case("d20_6", 20, 6, 3, 2, 0, 7, 6);

        for (int a = 0; a < 64; a++) begin
            for (int b = 1; b < 64; b++) begin
                apply(a, b);
                wait_done(1, k, nb);
                chk("sweep_q", int'(bus.quotient), a / b);
                chk("sweep_r", int'(bus.remainder), a % b);
                chk("sweep_rlt", int'(int'(bus.remainder) < b), 1);
            end
        end
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
